// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words and pulses word_valid per word.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              byte_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic              last_c,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [BCNT_W-1:0]        cnt_q;
  logic [WORD_W-BYTE_W-1:0] shift_q;

  // The byte about to be accepted completes the current word.
  assign last_c = (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));

  // Byte counter (wraps 3->0), shift register and registered word output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        cnt_q   <= '0;
        shift_q <= '0;
      end else if (byte_en) begin
        cnt_q   <= cnt_q + BCNT_W'(1);
        shift_q <= {shift_q[WORD_W-2*BYTE_W-1:0], byte_in};
        if (last_c) begin
          word       <= {shift_q, byte_in};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header, payload words, XOR checksum; holds the core in reset until verified.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [AW-1:0]     imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_resetn,
  output logic              load_done,
  output logic              load_error
);

  localparam int unsigned CW = AW + 1;

  loader_state_t     state_q, state_d;
  logic              hs_c, start_c, last_c;
  logic [CW-1:0]     n_q, word_cnt_q;
  logic [BYTE_W-1:0] csum_q;

  // Status outputs decoded directly from the state register.
  assign byte_ready  = (state_q == HDR) || (state_q == DATA) || (state_q == CSUM);
  assign core_resetn = (state_q == DONE);
  assign load_done   = (state_q == DONE);
  assign load_error  = (state_q == ERR);

  assign hs_c    = byte_valid && byte_ready;
  assign start_c = load_start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

  imem_word_assembler u_asm (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (start_c),
    .byte_en    (hs_c && (state_q == DATA)),
    .byte_in    (byte_data),
    .last_c     (last_c),
    .word_valid (imem_we),
    .word       (imem_wdata)
  );

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start_c) state_d = HDR;
      end
      HDR: begin
        if (hs_c) begin
          if ((byte_data == '0) || (32'(byte_data) > DEPTH)) state_d = ERR;
          else                                                state_d = DATA;
        end
      end
      DATA: begin
        if (hs_c && last_c && ((word_cnt_q + CW'(1)) == n_q)) state_d = CSUM;
      end
      CSUM: begin
        if (hs_c) state_d = (byte_data == csum_q) ? DONE : ERR;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word count, running checksum, header latch and write address.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      n_q        <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      imem_addr  <= '0;
    end else begin
      if (start_c) begin
        word_cnt_q <= '0;
        csum_q     <= '0;
      end
      if ((state_q == HDR) && hs_c) n_q <= CW'(byte_data);
      if ((state_q == DATA) && hs_c) begin
        csum_q <= csum_q ^ byte_data;
        if (last_c) begin
          imem_addr  <= word_cnt_q[AW-1:0];
          word_cnt_q <= word_cnt_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus, checked at imem_we.
module tb_imem_loader;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic          clk = 1'b0;
  logic          resetn;
  logic          load_start;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_resetn;
  logic          load_done;
  logic          load_error;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          we_cnt   = 0;
  bit          written [DEPTH];
  logic [31:0] img [DEPTH];

  imem_loader #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .load_start  (load_start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .core_resetn (core_resetn),
    .load_done   (load_done),
    .load_error  (load_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Each write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t e;
    if (resetn && imem_we === 1'b1) begin
      we_cnt++;
      written[imem_addr] = 1'b1;
      check("write_expected", 64'(sb.size() != 0), 64'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("write_addr", 64'(imem_addr), 64'(e.addr));
        check("write_data", 64'(imem_wdata), 64'(e.data));
      end
    end
  end

  // Present one byte, wait for the handshake, then idle for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int budget = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    while (!byte_ready && budget < 50) begin
      budget++;
      @(negedge clk);
    end
    if (budget >= 50) check("byte_ready_timeout", 64'(byte_ready), 64'(1));
    @(posedge clk); #1;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Full load of img[0..n-1] with checksum byte cs; outcome predicted from the stream.
  task automatic load_image(input logic [7:0] n, input logic [7:0] cs, input int gap);
    logic [7:0]  x = 8'h00;
    logic [31:0] w;
    logic [7:0]  b;
    bit          hdr_ok;
    bit          ok;
    int          we0;
    hdr_ok = (n != 8'd0) && (32'(n) <= DEPTH);
    we0    = we_cnt;
    pulse_start();
    check("start_core_resetn", 64'(core_resetn), 64'(0));
    check("start_byte_ready", 64'(byte_ready), 64'(1));
    send_byte(n, gap);
    if (hdr_ok) begin
      for (int k = 0; k < int'(n); k++) begin
        w = img[k];
        sb.push_back({AW'(k), w});
        for (int j = 0; j < 4; j++) begin
          b = w[31-8*j -: 8];
          x = x ^ b;
          send_byte(b, gap);
        end
      end
      send_byte(cs, gap);
    end
    ok = hdr_ok && (cs == x);
    check("load_done", 64'(load_done), 64'(ok));
    check("load_error", 64'(load_error), 64'(!ok));
    check("core_resetn", 64'(core_resetn), 64'(ok));
    check("byte_ready_after", 64'(byte_ready), 64'(0));
    check("we_count", 64'(we_cnt - we0), hdr_ok ? 64'(n) : 64'(0));
    check("sb_drained", 64'(sb.size()), 64'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_ready"}, 64'(byte_ready), 64'(0));
    check({tag, "_imem_we"}, 64'(imem_we), 64'(0));
    check({tag, "_imem_addr"}, 64'(imem_addr), 64'(0));
    check({tag, "_imem_wdata"}, 64'(imem_wdata), 64'(0));
    check({tag, "_core_resetn"}, 64'(core_resetn), 64'(0));
    check({tag, "_load_done"}, 64'(load_done), 64'(0));
    check({tag, "_load_error"}, 64'(load_error), 64'(0));
  endtask

  task automatic set_nominal();
    img[0] = 32'h9000000A;
    img[1] = 32'h90010004;
    img[2] = 32'h040117FF;
    img[3] = 32'hFC000000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] cs;
    resetn     = 1'b0;
    load_start = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    for (int i = 0; i < int'(DEPTH); i++) begin
      img[i]     = 32'h0;
      written[i] = 1'b0;
    end
    set_nominal();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    check("idle_byte_ready", 64'(byte_ready), 64'(0));

    // Nominal, bad checksum, bad headers, stalled source.
    load_image(8'h04, 8'h1E, 0);
    load_image(8'h04, 8'h1F, 0);
    load_image(8'h00, 8'h00, 0);
    load_image(8'd17, 8'h00, 0);
    load_image(8'h04, 8'h1E, 3);

    // Reset after six payload bytes: word 0 written, word 1 not.
    for (int i = 0; i < int'(DEPTH); i++) written[i] = 1'b0;
    pulse_start();
    send_byte(8'h04, 0);
    sb.push_back({AW'(0), img[0]});
    for (int j = 0; j < 4; j++) send_byte(img[0][31-8*j -: 8], 0);
    send_byte(img[1][31:24], 0);
    send_byte(img[1][23:16], 0);
    resetn = 1'b0;
    #1;
    check_reset_outputs("midload");
    check("midload_addr0_written", 64'(written[0]), 64'(1));
    check("midload_addr1_written", 64'(written[1]), 64'(0));
    check("midload_sb_drained", 64'(sb.size()), 64'(0));
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    check("midload_idle_ready", 64'(byte_ready), 64'(0));
    load_image(8'h04, 8'h1E, 0);

    // Reload from DONE with a one-word image.
    img[0] = 32'h12345678;
    load_image(8'h01, 8'h08, 0);

    // Full-depth image.
    cs = 8'h00;
    for (int i = 0; i < int'(DEPTH); i++) begin
      img[i] = $urandom;
      cs = cs ^ img[i][31:24] ^ img[i][23:16] ^ img[i][15:8] ^ img[i][7:0];
    end
    load_image(8'(DEPTH), cs, 0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
